// File: rtl/chip_seq_ctrl.sv
// Command sequencer driving the memory-array chip port: host commands become timed
// strobes, addresses and chip clock pulses. Define CHIP_SEQ_VERIFY_EN for program read-back.
module chip_seq_ctrl #(
  parameter int SETUP_CYCLES = 2,
  parameter int PROG_CYCLES  = 16,
  parameter int INF_CYCLES   = 255,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [2:0]         cmd_op_i,
  input  logic [7:0]         cmd_row_i,
  input  logic [7:0]         cmd_col_i,
  input  logic [7:0]         cmd_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [4*CNT_W-1:0] rsp_data_o,
  output logic               rsp_err_o,
  output logic               chip_clk_o,
  output logic               cbl_o,
  output logic               cblen_o,
  output logic               cwl_o,
  output logic               inference_o,
  output logic               load_seed_o,
  output logic               read_1_o,
  output logic               read_8_o,
  output logic               load_mem_o,
  output logic               read_out_o,
  output logic               stoch_log_o,
  output logic [7:0]         addr_full_col_o,
  output logic [7:0]         addr_full_row_o,
  output logic [7:0]         seeds_o,
  input  logic [3:0]         bit_out_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_INF_LO, S_INF_HI, S_HOLD, S_DONE
  } state_e;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_SEED  = 3'd1;
  localparam logic [2:0] OP_PROG  = 3'd2;
  localparam logic [2:0] OP_READ1 = 3'd3;
  localparam logic [2:0] OP_READ8 = 3'd4;
  localparam logic [2:0] OP_INFER = 3'd5;

  localparam int MAX_AB = (SETUP_CYCLES > PROG_CYCLES) ? SETUP_CYCLES : PROG_CYCLES;
  localparam int MAXC   = (MAX_AB > INF_CYCLES) ? MAX_AB : INF_CYCLES;
  localparam int CW     = $clog2(MAXC + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            vfy_q, vfy_d;
  logic            accept;
  logic            dbit_d;

  logic            cmd_ready_q, rsp_valid_q, rsp_err_q;
  logic [4*CNT_W-1:0] rsp_data_q;
  logic [7:0]      row_q, col_q, seeds_q;
  logic            chip_clk_q, cbl_q, cblen_q, cwl_q, inference_q, load_seed_q;
  logic            read_1_q, read_8_q, load_mem_q, read_out_q, stoch_log_q;
  logic            chip_clk_d, cbl_d, cblen_d, cwl_d, inference_d, load_seed_d;
  logic            read_1_d, read_8_d, load_mem_d, read_out_d, stoch_log_d;

  assign accept = cmd_valid_i && cmd_ready_q;
  assign dbit_d = accept ? cmd_data_i[0] : seeds_q[0];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    vfy_d   = vfy_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = cmd_op_i;
          vfy_d = 1'b0;
          cnt_d = '0;
          if (cmd_op_i != OP_NOP && cmd_op_i <= OP_INFER) state_d = S_SETUP;
          else                                            state_d = S_DONE;
        end
      end
      S_SETUP: begin
        if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
          cnt_d   = '0;
          // The last setup cycle doubles as the low half of the first chip clock period.
          state_d = (op_q == OP_INFER) ? S_INF_HI : S_PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PULSE: begin
        if (op_q == OP_PROG && !vfy_q && cnt_q != CW'(PROG_CYCLES - 1)) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end
      S_INF_HI: begin
        if (cnt_q == CW'(INF_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_INF_LO;
        end
      end
      S_INF_LO: state_d = S_INF_HI;
      S_HOLD: begin
`ifdef CHIP_SEQ_VERIFY_EN
        if (op_q == OP_PROG && !vfy_q) begin
          vfy_d   = 1'b1;
          state_d = S_SETUP;
        end else begin
          state_d = S_DONE;
        end
`else
        state_d = S_DONE;
`endif
      end
      S_DONE: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: derived from the next state so strobes are registered and line up with it
  always_comb begin
    logic busy;
    chip_clk_d  = 1'b0;
    cbl_d       = 1'b0;
    cblen_d     = 1'b0;
    cwl_d       = 1'b0;
    inference_d = 1'b0;
    load_seed_d = 1'b0;
    read_1_d    = 1'b0;
    read_8_d    = 1'b0;
    load_mem_d  = 1'b0;
    read_out_d  = 1'b0;
    stoch_log_d = 1'b0;
    busy = (state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_INF_LO) ||
           (state_d == S_INF_HI) || (state_d == S_HOLD);
    if (busy) begin
      if (vfy_d) begin
        read_1_d   = 1'b1;
        read_out_d = 1'b1;
      end else begin
        case (op_d)
          OP_SEED:  load_seed_d = 1'b1;
          OP_PROG:  load_mem_d  = 1'b1;
          OP_READ1: begin read_1_d = 1'b1; read_out_d = 1'b1; end
          OP_READ8: begin read_8_d = 1'b1; read_out_d = 1'b1; end
          OP_INFER: begin inference_d = 1'b1; stoch_log_d = dbit_d; end
          default: ;
        endcase
      end
    end
    if (state_d == S_PULSE) begin
      if (op_d == OP_PROG && !vfy_d) begin
        cwl_d   = 1'b1;
        cblen_d = 1'b1;
        cbl_d   = dbit_d;
      end else begin
        chip_clk_d = 1'b1;
      end
    end
    if (state_d == S_INF_HI) chip_clk_d = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_NOP;
      vfy_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      seeds_q     <= '0;
      chip_clk_q  <= 1'b0;
      cbl_q       <= 1'b0;
      cblen_q     <= 1'b0;
      cwl_q       <= 1'b0;
      inference_q <= 1'b0;
      load_seed_q <= 1'b0;
      read_1_q    <= 1'b0;
      read_8_q    <= 1'b0;
      load_mem_q  <= 1'b0;
      read_out_q  <= 1'b0;
      stoch_log_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      vfy_q       <= vfy_d;
      cmd_ready_q <= (state_d == S_IDLE);
      rsp_valid_q <= (state_d == S_DONE);
      chip_clk_q  <= chip_clk_d;
      cbl_q       <= cbl_d;
      cblen_q     <= cblen_d;
      cwl_q       <= cwl_d;
      inference_q <= inference_d;
      load_seed_q <= load_seed_d;
      read_1_q    <= read_1_d;
      read_8_q    <= read_8_d;
      load_mem_q  <= load_mem_d;
      read_out_q  <= read_out_d;
      stoch_log_q <= stoch_log_d;
      if (accept) begin
        row_q      <= cmd_row_i;
        col_q      <= cmd_col_i;
        seeds_q    <= cmd_data_i;
        rsp_data_q <= '0;
        rsp_err_q  <= (cmd_op_i > OP_INFER);
      end
      if (state_q == S_PULSE && (op_q == OP_READ1 || op_q == OP_READ8 || vfy_q)) begin
        rsp_data_q <= {{(4*CNT_W-4){1'b0}}, bit_out_i};
`ifdef CHIP_SEQ_VERIFY_EN
        if (vfy_q) rsp_err_q <= (bit_out_i[0] != seeds_q[0]);
`endif
      end
      if (state_q == S_INF_HI) begin
        for (int i = 0; i < 4; i++) begin
          if (bit_out_i[i] && rsp_data_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})
            rsp_data_q[i*CNT_W +: CNT_W] <= rsp_data_q[i*CNT_W +: CNT_W] + 1'b1;
        end
      end
    end
  end

  assign cmd_ready_o     = cmd_ready_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_data_o      = rsp_data_q;
  assign rsp_err_o       = rsp_err_q;
  assign chip_clk_o      = chip_clk_q;
  assign cbl_o           = cbl_q;
  assign cblen_o         = cblen_q;
  assign cwl_o           = cwl_q;
  assign inference_o     = inference_q;
  assign load_seed_o     = load_seed_q;
  assign read_1_o        = read_1_q;
  assign read_8_o        = read_8_q;
  assign load_mem_o      = load_mem_q;
  assign read_out_o      = read_out_q;
  assign stoch_log_o     = stoch_log_q;
  assign addr_full_col_o = col_q;
  assign addr_full_row_o = row_q;
  assign seeds_o         = seeds_q;

endmodule

// File: tb/tb_chip_seq_ctrl.sv
// Directed bench for chip_seq_ctrl: default instance plus a long-INFER (300 period) instance.
module tb_chip_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_valid2 = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  cmd_row = '0, cmd_col = '0, cmd_data = '0;
  logic        rsp_ready = 1'b0, rsp_ready2 = 1'b0;
  logic [3:0]  bit_out = '0;

  logic        cmd_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic        chip_clk, cbl, cblen, cwl, inference, load_seed, read_1, read_8, load_mem, read_out, stoch_log;
  logic [7:0]  addr_col, addr_row, seeds;

  logic        cmd_ready2, rsp_valid2, rsp_err2;
  logic [31:0] rsp_data2;
  logic        chip_clk2, cbl2, cblen2, cwl2, inference2, load_seed22, read_12, read_82, load_mem2, read_out2, stoch_log2;
  logic [7:0]  addr_col2, addr_row2, seeds2;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  chip_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_row_i(cmd_row), .cmd_col_i(cmd_col), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .chip_clk_o(chip_clk), .cbl_o(cbl), .cblen_o(cblen), .cwl_o(cwl), .inference_o(inference),
    .load_seed_o(load_seed), .read_1_o(read_1), .read_8_o(read_8), .load_mem_o(load_mem),
    .read_out_o(read_out), .stoch_log_o(stoch_log),
    .addr_full_col_o(addr_col), .addr_full_row_o(addr_row), .seeds_o(seeds),
    .bit_out_i(bit_out)
  );

  chip_seq_ctrl #(.INF_CYCLES(300), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid2), .cmd_ready_o(cmd_ready2), .cmd_op_i(cmd_op),
    .cmd_row_i(cmd_row), .cmd_col_i(cmd_col), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2), .rsp_data_o(rsp_data2), .rsp_err_o(rsp_err2),
    .chip_clk_o(chip_clk2), .cbl_o(cbl2), .cblen_o(cblen2), .cwl_o(cwl2), .inference_o(inference2),
    .load_seed_o(load_seed22), .read_1_o(read_12), .read_8_o(read_82), .load_mem_o(load_mem2),
    .read_out_o(read_out2), .stoch_log_o(stoch_log2),
    .addr_full_col_o(addr_col2), .addr_full_row_o(addr_row2), .seeds_o(seeds2),
    .bit_out_i(bit_out)
  );

  wire [10:0] strobes = {chip_clk, cbl, cblen, cwl, inference, load_seed, read_1, read_8,
                         load_mem, read_out, stoch_log};
  wire any_out = (|strobes) | cmd_ready | rsp_valid | rsp_err | (|rsp_data) |
                 (|addr_col) | (|addr_row) | (|seeds);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle T+1 of the accepted command.
  task automatic issue(input logic [2:0] op, input logic [7:0] row, input logic [7:0] col,
                       input logic [7:0] data);
    int w;
    w = 0;
    while (!cmd_ready && w < 50) begin tick(); w++; end
    chk("issue_ready", cmd_ready, 1'b1);
    cmd_op = op; cmd_row = row; cmd_col = col; cmd_data = data;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic ack;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n, hi, first, stall_bad;
    logic [31:0] held;

    #2;
    chk("reset_outputs", any_out, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", cmd_ready, 1'b1);

    // LOAD_SEED 0xA5 at row 3
    issue(3'd1, 8'h03, 8'h00, 8'hA5);
    chk("seed_bus_t1", seeds, 8'hA5);
    chk("seed_row_t1", addr_row, 8'h03);
    chk("seed_strobe_t1", {load_seed, chip_clk, cmd_ready}, 3'b100);
    tick();
    chk("seed_t2", {load_seed, chip_clk}, 2'b10);
    tick();
    chk("seed_t3_pulse", {load_seed, chip_clk}, 2'b11);
    tick();
    chk("seed_t4_hold", {load_seed, chip_clk, rsp_valid}, 3'b100);
    tick();
    chk("seed_t5_rsp", {load_seed, rsp_valid, rsp_err}, 3'b010);
    ack();
    chk("seed_idle_again", cmd_ready, 1'b1);

    // PROGRAM row 0x12 col 0x34 level 1
    issue(3'd2, 8'h12, 8'h34, 8'h01);
    chk("prog_load_mem_t1", load_mem, 1'b1);
    n = 1; hi = 0; first = 0;
    while (!rsp_valid && n < 100) begin
      if (cwl && cblen && cbl) begin hi++; if (first == 0) first = n; end
      if (chip_clk) hi = hi + 1000;
      tick(); n++;
    end
    chk("prog_pulse_width", hi, 16);
    chk("prog_pulse_start", first, 3);
    chk("prog_latency", n, 20);
    chk("prog_rsp", {rsp_err, rsp_data}, 33'h0);
    chk("prog_addr", {addr_row, addr_col}, 16'h1234);
    chk("prog_strobe_off", load_mem, 1'b0);
    ack();

    // READ1 with bit_out = 9
    bit_out = 4'h9;
    issue(3'd3, 8'h01, 8'h02, 8'h00);
    chk("read1_mode_t1", {read_1, read_out, read_8}, 3'b110);
    n = 1;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    chk("read1_latency", n, 5);
    chk("read1_data", rsp_data, 32'h9);
    ack();

    // READ8 with bit_out = C and a stalled response
    bit_out = 4'hC;
    issue(3'd4, 8'h05, 8'h06, 8'h3C);
    chk("read8_mode_t1", {read_8, read_out, read_1}, 3'b110);
    n = 1;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    chk("read8_latency", n, 5);
    chk("read8_data", rsp_data, 32'hC);
    bit_out = 4'h0;
    held = rsp_data;
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin cmd_op = 3'd1; cmd_data = 8'h77; cmd_valid = 1'b1; end
      if (i == 5) cmd_valid = 1'b0;
      if (!rsp_valid || rsp_data !== held || cmd_ready) stall_bad++;
      tick();
    end
    chk("read8_stall_stable", stall_bad, 0);
    ack();
    chk("read8_ignored_cmd", {cmd_ready, seeds, load_seed}, {1'b1, 8'h3C, 1'b0});

    // Illegal op 7 and NOP
    issue(3'd7, 8'hFF, 8'hFF, 8'hFF);
    chk("illegal_rsp_t1", {rsp_valid, rsp_err, rsp_data}, {2'b11, 32'h0});
    chk("illegal_no_strobe", strobes, 11'h0);
    ack();
    issue(3'd0, 8'h00, 8'h00, 8'h00);
    chk("nop_rsp_t1", {rsp_valid, rsp_err}, 2'b10);
    ack();

    // INFER, bit_out = 0101, stoch_log = 1
    bit_out = 4'b0101;
    issue(3'd5, 8'h00, 8'h00, 8'h01);
    chk("infer_mode_t1", {inference, stoch_log, chip_clk}, 3'b110);
    n = 1; hi = 0;
    while (!rsp_valid && n < 2000) begin
      if (chip_clk) hi++;
      tick(); n++;
    end
    chk("infer_clk_pulses", hi, 255);
    chk("infer_latency", n, 513);
    chk("infer_counts", rsp_data, 32'h00FF00FF);
    ack();

    // Long INFER on the 300-period instance: counters saturate
    bit_out = 4'b1111;
    cmd_op = 3'd5; cmd_data = 8'h00;
    chk("infer300_ready", cmd_ready2, 1'b1);
    cmd_valid2 = 1'b1;
    tick();
    cmd_valid2 = 1'b0;
    n = 1;
    while (!rsp_valid2 && n < 2000) begin tick(); n++; end
    chk("infer300_latency", n, 603);
    chk("infer300_sat", rsp_data2, 32'hFFFFFFFF);
    rsp_ready2 = 1'b1; tick(); rsp_ready2 = 1'b0;

    // Reset in the middle of INFER
    bit_out = 4'b0011;
    issue(3'd5, 8'h44, 8'h55, 8'h01);
    n = 1;
    while (n < 100) begin tick(); n++; end
    chk("infer_running", inference, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", any_out, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_ready", cmd_ready, 1'b1);
    hi = 0;
    for (int i = 0; i < 600; i++) begin
      if (rsp_valid || inference) hi++;
      tick();
    end
    chk("midrst_no_rsp", hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chip_seq_ctrl.md
Name: chip_seq_ctrl

Overview:
- Command-driven sequencer that owns the Master side of the chip port bundle.
- Turns host commands (seed load, cell program, single/8-way read, stochastic inference) into correctly ordered, timed control strobes, addresses and chip clock pulses.
- Returns read bits or per-class inference counts on a response channel.
- Sits between the host/test controller and the memory-array chip.

Parameters:
- SETUP_CYCLES, 2: clk cycles that addresses, data and mode strobes are stable before any pulse; must be >=1.
- PROG_CYCLES, 16: CWL/CBLEN pulse width for PROGRAM, in clk cycles; must be >=1.
- INF_CYCLES, 255: chip clock periods per INFER; must be >=1.
- CNT_W, 8: width of each per-class inference counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  controller idle and accepting a command
- cmd_op  in  3  0 NOP, 1 LOAD_SEED, 2 PROGRAM, 3 READ1, 4 READ8, 5 INFER, 6-7 illegal
- cmd_row  in  8  row address
- cmd_col  in  8  column address
- cmd_data  in  8  seed value (LOAD_SEED); bit0 = CBL level (PROGRAM) or stoch_log (INFER)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_data  out  4*CNT_W  READ: [3:0] = bit_out, rest 0; INFER: class i count in [i*CNT_W +: CNT_W]
- rsp_err  out  1  illegal opcode (or verify mismatch, see Optional Feature)
- chip_clk, cbl, cblen, cwl, inference, load_seed, read_1, read_8, load_mem, read_out, stoch_log  out  1 each  chip controls
- addr_full_col, addr_full_row, seeds  out  8 each  chip address and seed bus
- bit_out  in  4  chip output bits

Behaviour:
- Reset, asynchronous: every output 0, counters 0, FSM in IDLE. Reset mid-operation aborts immediately; no response is issued.
- All chip outputs are registered; no combinational path from any input to any output.
- Handshake:
  - Command is accepted on cmd_valid && cmd_ready (cycle T). cmd_ready is 1 only in IDLE.
  - cmd_* fields are latched at T. addr_full_row/col and seeds update at T+1 and hold until the next accept.
  - rsp_valid stays high, with rsp_data/rsp_err stable, until rsp_ready. IDLE is re-entered the cycle after the handshake.
- FSM states: IDLE -> SETUP -> PULSE | INF_LO/INF_HI -> HOLD -> DONE -> IDLE.
- NOP or illegal op: IDLE -> DONE. rsp_valid at T+1, rsp_data 0, rsp_err = 1 for illegal ops only.
- SETUP (SETUP_CYCLES cycles), mode strobe high:
  - load_seed for LOAD_SEED.
  - load_mem for PROGRAM.
  - read_1 + read_out for READ1; read_8 + read_out for READ8.
  - inference for INFER, with stoch_log = cmd_data[0].
- The mode strobe stays high through PULSE/INF and HOLD, and drops on entry to DONE.
- PULSE:
  - LOAD_SEED, READ1, READ8: chip_clk high for 1 cycle. READ samples bit_out at the end of that cycle.
  - PROGRAM: cblen = cwl = 1 and cbl = cmd_data[0] for PROG_CYCLES cycles.
- INFER:
  - chip_clk alternates low/high each clk (INF_LO then INF_HI) for INF_CYCLES periods.
  - bit_out[i] is sampled on each INF_HI cycle; counter i increments if set and saturates at 2^CNT_W-1.
  - Counters clear when INFER is accepted.
- HOLD: 1 cycle with all pulses low, then DONE.
- Latency from accept T to rsp_valid, at defaults:
  - LOAD_SEED, READ: T+5.
  - PROGRAM: T+20.
  - INFER: T+3+2*INF_CYCLES = T+513.
- cmd_valid while busy is ignored; the command is held off by cmd_ready = 0.

Optional Feature:
- Macro: CHIP_SEQ_VERIFY_EN.
- When defined:
  - After PROGRAM's HOLD, the controller runs an internal READ1 at the same address (SETUP, 1-cycle chip_clk pulse, HOLD).
  - rsp_data[3:0] = read bits.
  - rsp_err = 1 if bit_out[0] != cmd_data[0].
  - PROGRAM latency becomes T+24.
- When undefined: PROGRAM returns rsp_data = 0 and rsp_err = 0.

Test Plan:
- Reset mid-INFER (rst_n low at T+100): all outputs 0 asynchronously, cmd_ready = 1 after release, no rsp_valid.
- LOAD_SEED with data 0xA5 at row 3: seeds = 0xA5 at T+1; load_seed high T+1..T+4; chip_clk high only at T+3; rsp_valid at T+5.
- PROGRAM row 0x12, col 0x34, data bit0 = 1: cwl = cblen = cbl = 1 for exactly 16 cycles (T+3..T+18); rsp_valid at T+20 (T+24 with VERIFY_EN and bit_out[0] = 1, giving rsp_err = 0).
- INFER with bit_out held at 4'b0101: after 513 cycles, counts = {0, 255, 0, 255}. Repeat with INF_CYCLES = 300, CNT_W = 8: counters saturate at 255.
- READ8 with bit_out = 4'hC and rsp_ready held low for 10 cycles: rsp_valid and rsp_data = 0xC stay stable; cmd_ready stays 0; a cmd_valid during the stall is ignored.
- cmd_op = 7: rsp_valid at T+1 with rsp_err = 1; no chip strobes toggle.
